// File: rtl/bus6502_pkg.sv
// Shared types and sizes for the 6502 bus sequencer.
// Optional readback path is enabled with BUS6502_READBACK_EN.
package bus6502_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 8;
    localparam int ADDR_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/bus6502_sync.sv
// Multi-flop synchroniser: one edge-detected bit plus W plain bits.
// All flops reset to RST_VAL so no false edge appears after reset.
module bus6502_sync #(
    parameter int   STAGES  = 2,
    parameter int   W       = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_edge,
    input  logic [W-1:0] i_d,
    output logic         o_rise,
    output logic         o_fall,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W:0] r_ff;
    logic                   r_edge_d;
    logic                   w_edge_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff     <= {(STAGES*(W+1)){RST_VAL}};
            r_edge_d <= RST_VAL;
        end else begin
            r_ff     <= {r_ff[STAGES-2:0], {i_edge, i_d}};
            r_edge_d <= w_edge_s;
        end
    end

    assign w_edge_s = r_ff[STAGES-1][W];
    assign o_q      = r_ff[STAGES-1][W-1:0];
    assign o_rise   = w_edge_s & ~r_edge_d;
    assign o_fall   = ~w_edge_s & r_edge_d;

endmodule

// File: rtl/bus6502_sequencer.sv
// 6502 bus-cycle sequencer into a 16x8 register file with a host port.
// Define BUS6502_READBACK_EN to drive 6502 read data onto data_out.
module bus6502_sequencer
    import bus6502_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DLY  = 20,
    parameter int LED_REG     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_ext1,
    input  logic                cs,
    input  logic [ADDR_W-1:0]   rs,
    input  logic                wren,
    input  logic [REG_W-1:0]    data_in,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [REG_W-1:0]    host_wdata,
    output logic                host_ack,
    output logic [REG_W-1:0]    host_rdata,
    output logic [NUM_REGS-1:0] newdata,
    output logic [REG_W-1:0]    led,
    output logic [REG_W-1:0]    data_out,
    output logic                data_oe
);

    localparam int CNT_W = $clog2(SAMPLE_DLY + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_DLY);
    localparam logic [ADDR_W-1:0] LED_IDX = ADDR_W'(LED_REG);

    logic [1:0]          w_sync;
    logic                w_rise;
    logic                w_fall;
    logic                w_cs_s;
    logic                w_wren_s;
    logic                w_hit;
    logic                w_commit;
    logic                w_take;
    logic [NUM_REGS-1:0] w_nd_set;
    logic [NUM_REGS-1:0] w_nd_clr;
    state_e              w_nxt;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [REG_W-1:0]    r_dq;
    logic [REG_W-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_newdata;
    logic                r_ack;
    logic                r_stall;
    logic [REG_W-1:0]    r_hrdata;
    logic                r_hwe;
    logic [ADDR_W-1:0]   r_haddr;
    logic [REG_W-1:0]    r_hwdata;
    logic [REG_W-1:0]    r_led;

    bus6502_sync #(
        .STAGES  (SYNC_STAGES),
        .W       (2),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_edge (clk_ext1),
        .i_d    ({wren, cs}),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_q    (w_sync)
    );

    assign w_cs_s   = w_sync[0];
    assign w_wren_s = w_sync[1];
    assign w_hit    = (r_state == ST_WAIT) && (r_cnt == CNT_MAX);
    assign w_commit = (r_state == ST_COMMIT);

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_rise && !w_cs_s) w_nxt = ST_ADDR;
            ST_ADDR:   w_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_hit)                w_nxt = r_wr ? ST_HOLD : ST_COMMIT;
                else if (w_cs_s || w_fall) w_nxt = ST_IDLE;
            end
            ST_COMMIT: w_nxt = w_fall ? ST_IDLE : ST_HOLD;
            ST_HOLD:   if (w_fall) w_nxt = ST_IDLE;
            default:   w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b1;
            r_dq    <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state == ST_ADDR) begin
                r_addr <= rs;
                r_wr   <= w_wren_s;
                r_cnt  <= '0;
            end else if (r_state == ST_WAIT) begin
                if (w_hit)
                    r_dq <= data_in;
                else if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A request seen during COMMIT reads immediately but stalls its write
    // and ack by one cycle, keeping the bus as sole writer that cycle.
    assign w_take   = host_req && !r_ack && !r_stall;
    assign w_nd_set = w_commit ? (NUM_REGS'(1) << r_addr) : '0;
    assign w_nd_clr = (w_take && !host_we) ? (NUM_REGS'(1) << host_addr) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_newdata <= '0;
            r_ack     <= 1'b0;
            r_stall   <= 1'b0;
            r_hrdata  <= '0;
            r_hwe     <= 1'b0;
            r_haddr   <= '0;
            r_hwdata  <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_commit) r_regs[r_addr] <= r_dq;
            if (r_stall) begin
                r_stall <= 1'b0;
                r_ack   <= 1'b1;
                if (r_hwe) r_regs[r_haddr] <= r_hwdata;
            end else if (w_take) begin
                r_hwe    <= host_we;
                r_haddr  <= host_addr;
                r_hwdata <= host_wdata;
                if (!host_we) r_hrdata <= r_regs[host_addr];
                if (w_commit) begin
                    r_stall <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    if (host_we) r_regs[host_addr] <= host_wdata;
                end
            end
            r_newdata <= (r_newdata & ~w_nd_clr) | w_nd_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_led <= '0;
        else        r_led <= r_regs[LED_IDX];
    end

    assign host_ack   = r_ack;
    assign host_rdata = r_hrdata;
    assign newdata    = r_newdata;
    assign led        = r_led;

`ifdef BUS6502_READBACK_EN
    logic [REG_W-1:0] r_dout;
    logic             r_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
            r_oe   <= 1'b0;
        end else if (r_state == ST_ADDR) begin
            if (w_wren_s) r_dout <= r_regs[rs];
            r_oe <= w_wren_s;
        end else if (w_nxt == ST_IDLE) begin
            r_oe <= 1'b0;
        end
    end

    assign data_out = r_dout;
    assign data_oe  = r_oe;
`else
    assign data_out = '0;
    assign data_oe  = 1'b0;
`endif

endmodule

// File: tb/tb_bus6502_sequencer.sv
// Directed bench for bus6502_sequencer: bus writes, aborts, host port,
// reset mid-cycle and (with BUS6502_READBACK_EN) the read drive path.
module tb_bus6502_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_ext1;
    logic        cs;
    logic [3:0]  rs;
    logic        wren;
    logic [7:0]  data_in;
    logic        host_req;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [15:0] newdata;
    logic [7:0]  led;
    logic [7:0]  data_out;
    logic        data_oe;

    int n_chk = 0;
    int n_bad = 0;

    bus6502_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_ext1   (clk_ext1),
        .cs         (cs),
        .rs         (rs),
        .wren       (wren),
        .data_in    (data_in),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .newdata    (newdata),
        .led        (led),
        .data_out   (data_out),
        .data_oe    (data_oe)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Rise lands on the 6th negedge after entry; COMMIT spans the 31st.
    task automatic bus_cycle(input logic [3:0] a, input logic wr_n,
                             input logic [7:0] d, input int abort_at,
                             input logic rb_chk, input logic rb_oe,
                             input logic [7:0] rb_dout);
        @(negedge clk);
        cs = 1'b0; rs = a; wren = wr_n; data_in = d;
        repeat (5) @(negedge clk);
        clk_ext1 = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == abort_at) cs = 1'b1;
            if (rb_chk && i == 10) begin
                chk("rb_oe", 16'(data_oe), 16'(rb_oe));
                chk("rb_dout", 16'(data_out), 16'(rb_dout));
            end
        end
        clk_ext1 = 1'b0;
        repeat (25) @(negedge clk);
        if (rb_chk) chk("rb_oe_end", 16'(data_oe), 16'h0);
        cs = 1'b1; wren = 1'b1;
    endtask

    task automatic host_rd(input string tag, input logic [3:0] a,
                           input logic [7:0] exp);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        chk({tag, "_ack"}, 16'(host_ack), 16'h1);
        chk(tag, 16'(host_rdata), 16'(exp));
        host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic out_zero(input string tag);
        chk({tag, "_led"}, 16'(led), 16'h0);
        chk({tag, "_nd"}, newdata, 16'h0);
        chk({tag, "_ack"}, 16'(host_ack), 16'h0);
        chk({tag, "_rdata"}, 16'(host_rdata), 16'h0);
        chk({tag, "_dout"}, 16'(data_out), 16'h0);
        chk({tag, "_oe"}, 16'(data_oe), 16'h0);
    endtask

    logic       rb_oe;
    logic [7:0] rb_dout;

    initial begin
`ifdef BUS6502_READBACK_EN
        rb_oe = 1'b1; rb_dout = 8'hC3;
`else
        rb_oe = 1'b0; rb_dout = 8'h00;
`endif
        rst_n = 1'b0; clk_ext1 = 1'b0; cs = 1'b1; rs = '0;
        wren = 1'b1; data_in = '0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0;
        repeat (3) @(negedge clk);
        out_zero("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        bus_cycle(4'd3, 1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00);
        chk("wr3_nd", newdata, 16'h0008);
        chk("wr3_led", 16'(led), 16'h0);
        host_rd("rd3", 4'd3, 8'hA5);
        chk("rd3_nd", newdata, 16'h0000);

        bus_cycle(4'd0, 1'b0, 8'h5A, 0, 1'b0, 1'b0, 8'h00);
        chk("led", 16'(led), 16'h005A);
        chk("led_nd", newdata, 16'h0001);

        fork
            bus_cycle(4'd3, 1'b0, 8'h11, 0, 1'b0, 1'b0, 8'h00);
            begin
                repeat (31) @(negedge clk);
                host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
                @(negedge clk);
                chk("col_ack_dly", 16'(host_ack), 16'h0);
                @(negedge clk);
                chk("col_ack", 16'(host_ack), 16'h1);
                chk("col_rdata", 16'(host_rdata), 16'h00A5);
                host_req = 1'b0;
            end
        join
        chk("col_nd", newdata, 16'h0009);
        host_rd("rd3b", 4'd3, 8'h11);
        chk("rd3b_nd", newdata, 16'h0001);

        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd7;
        host_wdata = 8'hC3;
        @(negedge clk);
        chk("hwr_ack", 16'(host_ack), 16'h1);
        host_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        chk("hwr_ack_pulse", 16'(host_ack), 16'h0);
        chk("hwr_nd", newdata, 16'h0001);
        host_rd("rd7", 4'd7, 8'hC3);

        bus_cycle(4'd7, 1'b1, 8'hEE, 0, 1'b1, rb_oe, rb_dout);
        chk("rb_nd", newdata, 16'h0001);
        host_rd("rd7b", 4'd7, 8'hC3);

        bus_cycle(4'd9, 1'b0, 8'h3C, 10, 1'b0, 1'b0, 8'h00);
        chk("abort_nd", newdata, 16'h0001);
        host_rd("abort_rd9", 4'd9, 8'h00);

        fork
            bus_cycle(4'd5, 1'b0, 8'h77, 0, 1'b0, 1'b0, 8'h00);
            begin
                repeat (16) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                out_zero("midrst");
                rst_n = 1'b1;
            end
        join
        chk("midrst_nd", newdata, 16'h0000);
        host_rd("midrst_rd5", 4'd5, 8'h00);
        host_rd("midrst_rd7", 4'd7, 8'h00);

        bus_cycle(4'd5, 1'b0, 8'h77, 0, 1'b0, 1'b0, 8'h00);
        chk("post_nd", newdata, 16'h0020);
        chk("post_led", 16'(led), 16'h0);
        host_rd("post_rd5", 4'd5, 8'h77);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bus6502_sequencer.md
Name: bus6502_sequencer

Overview:
- Sequences 6502 bus cycles into a 16 x 8 register file, entirely in the 50 MHz `clk` domain.
- Synchronises the external 1 MHz phi2 and the chip-select, and captures address, direction and data at fixed points in each cycle.
- Commits 6502 writes to the register file and shares the file with one internal host port.
- Drives the LED byte and a per-register "new data" flag vector.

Parameters:
- SYNC_STAGES, 2, flops in the phi2/cs/wren synchronisers (min 2)
- SAMPLE_DLY, 20, clk cycles after the detected phi2 rise at which data_in is sampled (must be less than the phi2-high time in clk cycles)
- LED_REG, 0, register index mirrored to led

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- clk_ext1  in  1  external 1 MHz phi2, asynchronous to clk
- cs  in  1  chip select, active low, asynchronous
- rs  in  4  register select
- wren  in  1  write enable, active low (0 = 6502 write)
- data_in  in  8  6502 data bus
- host_req  in  1  host access request, held high until host_ack
- host_we  in  1  1 = host write, 0 = host read
- host_addr  in  4  host register index
- host_wdata  in  8  host write data
- host_ack  out  1  one-cycle acknowledge
- host_rdata  out  8  read data, valid with host_ack
- newdata  out  16  bit i set when the 6502 writes reg i
- led  out  8  copy of reg[LED_REG]
- data_out  out  8  6502 read data (READBACK_EN only)
- data_oe  out  1  data bus drive enable (READBACK_EN only)

Behaviour:
- Reset: all registers, led, newdata, host_ack, host_rdata, data_out and data_oe are 0; FSM in IDLE.
- Reset asserted mid-cycle aborts the cycle with no commit. After release, the FSM waits in IDLE for the next clean phi2 rise and ignores any cycle already in progress.
- Synchronisers: clk_ext1, cs and wren each pass through SYNC_STAGES flops.
  - rise = phi2_s & ~phi2_s_d
  - fall = ~phi2_s & phi2_s_d
- FSM states:
  - IDLE: on rise with cs_s=0 → ADDR.
  - ADDR (1 cycle): latch rs and wren_s into addr_q and wr_q; clear counter → WAIT.
  - WAIT: increment the counter each cycle.
    - If cs_s=1 or fall is seen before the counter reaches SAMPLE_DLY: abort, no write → IDLE.
    - At counter==SAMPLE_DLY: latch data_in into data_q; → COMMIT if wr_q=0, else → HOLD.
  - COMMIT (1 cycle): reg[addr_q] <= data_q; newdata[addr_q] <= 1 → HOLD.
  - HOLD: on fall → IDLE.
- One bus transaction per phi2 period. A rise seen in any state other than IDLE is ignored.
- Host arbitration: single register-file write port; the bus has priority.
  - A host request is served in any cycle in which the FSM is not in COMMIT.
  - host_ack pulses 1 cycle later (two-cycle handshake: request sampled, ack returned).
  - A host write lands on the ack cycle.
  - host_rdata = reg[host_addr] as it stood before any same-cycle commit.
  - A host read clears newdata[host_addr] on the ack cycle.
  - The host must drop or change host_req after ack; a still-high host_req starts a new access.
- Simultaneous events:
  - A bus commit and a host read of the same index in one cycle: the set wins, so newdata stays 1.
  - A bus commit and a host write are never granted in the same cycle (bus first; host is acked the following cycle).
- led updates the cycle after any write to LED_REG.
- Widths: counter is $clog2(SAMPLE_DLY+1) bits and saturates; no wrap.

Optional Feature:
- Macro: BUS6502_READBACK_EN.
- Defined:
  - For wr_q=1 cycles, data_out = reg[addr_q], registered in ADDR.
  - data_oe = 1 from the cycle after ADDR until fall or abort.
- Undefined: data_out and data_oe are tied to 0 and the read path is not synthesised.

Decomposition:
- Package bus6502_pkg: FSM state enum (IDLE, ADDR, WAIT, COMMIT, HOLD), NUM_REGS=16, REG_W=8, ADDR_W=4.
- Sub-module bus6502_sync: parameterised SYNC_STAGES synchroniser plus edge detector, instanced for phi2; plain synchronisers for cs and wren.

Test Plan:
- 6502 write: rs=3, data_in=0xA5, wren=0, cs=0 over a full phi2 period → reg[3]=0xA5, newdata=0x0008, led unchanged.
- 6502 write to LED_REG: rs=0, data 0x5A → led=0x5A within 2 clk of COMMIT.
- cs deasserted 10 clk after rise in a write cycle → no register change, FSM returns to IDLE, newdata unchanged.
- Host read of reg 3 in the same cycle as a bus COMMIT to reg 3 (data 0x11):
  - host_ack is delayed one cycle;
  - host_rdata returns the old or new value per the rule above;
  - newdata[3] remains 1.
- Host write 0xC3 to reg 7 while the bus is idle → host_ack one cycle later, reg[7]=0xC3, newdata unchanged. A subsequent host read of reg 7 returns 0xC3.
- rst_n pulsed low during WAIT → all outputs 0, no commit; the next full cycle writes normally. With BUS6502_READBACK_EN: a 6502 read of reg 7 drives data_out=0xC3 with data_oe=1 until phi2 fall.
